// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit_pkg                                                  |
// | Purpose  : Shared constants and the state encoding for the IF-stage fetch  |
// |            engine (fetch_unit, inst_hold_buffer, fetch_unit_if).           |
// | Contents : DEFAULT_XLEN, DEFAULT_RESET_PC, DEFAULT_NOP_INST, fetch_state_t |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fetch_unit_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  // FETCH   : request outstanding (or about to be issued)
  // HOLD    : instruction captured, waiting for the stall to release
  // DISCARD : a stale request is still in flight after a redirect
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit_if                                                   |
// | Purpose  : Instruction-memory request/response bus, single outstanding.    |
// | Signals  : req   - fetch request valid (master -> slave)                   |
// |            addr  - fetch address       (master -> slave)                   |
// |            ready - response valid      (slave -> master)                   |
// |            rdata - instruction word    (slave -> master)                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);

endinterface
`default_nettype wire

// File: rtl/fetch_unit_inst_hold_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inst_hold_buffer                                                |
// | Purpose  : Registered {pc, inst, valid} used to park a fetched instruction |
// |            while the IF stage is stalled.                                  |
// | Ports    : clk, rst (async, active high)                                   |
// |            load, clear       - capture / empty the buffer                  |
// |            pc_in, inst_in    - values captured on load                     |
// |            pc, inst, valid   - buffer contents                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module inst_hold_buffer
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [31:0]     NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     inst_in,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      inst  <= inst_in;
      valid <= 1'b1;
    end else if (clear) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                      |
// | Purpose  : IF-stage fetch engine. Owns the PC, issues one-outstanding      |
// |            fetches on imem, presents {pc, inst, valid} to IF/ID and        |
// |            reports fetch_busy to the hazard unit.                          |
// | Ports    : clk, rst (async, active high)                                   |
// |            stall_if, bubble_if       - hazard unit controls               |
// |            pc_src_id, target_id      - redirect from ID                    |
// |            imem (fetch_unit_if.master) - instruction memory bus            |
// |            pc_if, inst_if, inst_valid_if - to IF/ID                        |
// |            fetch_busy                - no instruction available            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter logic [31:0]     NOP_INST = DEFAULT_NOP_INST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_if,
  input  logic             bubble_if,
  input  logic             pc_src_id,
  input  logic [XLEN-1:0]  target_id,
  fetch_unit_if.master     imem,
  output logic [XLEN-1:0]  pc_if,
  output logic [31:0]      inst_if,
  output logic             inst_valid_if,
  output logic             fetch_busy
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            req_en;      // low for the reset cycle so the first request follows rst release
  logic            req;
  logic            rsp;         // response accepted: ready only counts with a live request
  logic            redirect;
  logic            hold_load, hold_clear;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_inst;
  logic            hold_valid;

  inst_hold_buffer #(
    .XLEN     (XLEN),
    .NOP_INST (NOP_INST)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .clear   (hold_clear),
    .pc_in   (pc_reg),
    .inst_in (imem.rdata),
    .pc      (hold_pc),
    .inst    (hold_inst),
    .valid   (hold_valid)
  );

  assign req       = req_en && (state != ST_HOLD);
  assign rsp       = req && imem.ready;
  assign redirect  = pc_src_id && !stall_if;
  assign imem.req  = req;
  assign imem.addr = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_FETCH;
      pc_reg <= RESET_PC;
      req_en <= 1'b0;
    end else begin
      state  <= state_next;
      pc_reg <= pc_next;
      req_en <= 1'b1;
    end
  end

  // Next state / PC. Priority: redirect > bubble > stall > advance.
  always_comb begin
    state_next = state;
    pc_next    = pc_reg;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (redirect) begin
      pc_next    = {target_id[XLEN-1:2], 2'b00};
      hold_clear = 1'b1;
      // A request still in flight would return data for the old PC.
      state_next = (req && !imem.ready) ? ST_DISCARD : ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (rsp) begin
            if (bubble_if) begin
              state_next = ST_FETCH;
            end else if (stall_if) begin
              hold_load  = 1'b1;
              state_next = ST_HOLD;
            end else begin
              pc_next = pc_reg + XLEN'(4);
            end
          end
        end
        ST_HOLD: begin
          if (bubble_if) begin
            hold_clear = 1'b1;
            state_next = ST_FETCH;
          end else if (!stall_if) begin
            hold_clear = 1'b1;
            pc_next    = pc_reg + XLEN'(4);
            state_next = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (rsp) state_next = ST_FETCH;
        end
        default: state_next = ST_FETCH;
      endcase
    end
  end

  // IF/ID outputs are combinational so a zero-wait response is usable in the same cycle.
  always_comb begin
    pc_if         = pc_reg;
    inst_if       = NOP_INST;
    inst_valid_if = 1'b0;
    fetch_busy    = (state == ST_FETCH) && req && !imem.ready;
    if (!redirect && !bubble_if) begin
      if (state == ST_FETCH && rsp) begin
        inst_if       = imem.rdata;
        inst_valid_if = 1'b1;
      end else if (state == ST_HOLD && hold_valid) begin
        pc_if         = hold_pc;
        inst_if       = hold_inst;
        inst_valid_if = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                   |
// | Purpose  : Directed self-checking bench for fetch_unit.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, bubble_if, pc_src_id;
  logic [31:0] target_id;
  logic        mem_ready;
  logic        mem_garbage;
  logic [31:0] pc_if, inst_if;
  logic        inst_valid_if, fetch_busy;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_if #(.XLEN(32)) imem ();

  // Memory word at address a is {16'hC0DE, a[15:0]}; garbage mode returns a marker instead.
  assign imem.ready = mem_ready;
  assign imem.rdata = mem_garbage ? 32'hDEAD_BEEF : {16'hC0DE, imem.addr[15:0]};

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .bubble_if     (bubble_if),
    .pc_src_id     (pc_src_id),
    .target_id     (target_id),
    .imem          (imem.master),
    .pc_if         (pc_if),
    .inst_if       (inst_if),
    .inst_valid_if (inst_valid_if),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem.req); end
    n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid_if); end
    n_checks++; if (inst_if !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", inst_if, NOP); end
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", fetch_busy); end
    step(); step();
    rst = 1'b0;
    #1;
    n_checks++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL release_req: got %b expected 0", imem.req); end
    step();
    n_checks++; if (imem.req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem.req); end
    n_checks++; if (imem.addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 00000000", imem.addr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] exp_inst [4] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++; if (pc_if !== exp_pc[i]) begin n_fail++; $display("FAIL zw_pc[%0d]: got %h expected %h", i, pc_if, exp_pc[i]); end
      n_checks++; if (inst_if !== exp_inst[i]) begin n_fail++; $display("FAIL zw_inst[%0d]: got %h expected %h", i, inst_if, exp_inst[i]); end
      n_checks++; if (inst_valid_if !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d]: got %b expected 1", i, inst_valid_if); end
      n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy[%0d]: got %b expected 0", i, fetch_busy); end
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_latency();
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0;
      #1;
      n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy[%0d]: got %b expected 1", i, fetch_busy); end
      n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL lat_valid[%0d]: got %b expected 0", i, inst_valid_if); end
      n_checks++; if (imem.addr !== 32'h10) begin n_fail++; $display("FAIL lat_addr[%0d]: got %h expected 00000010", i, imem.addr); end
      step();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL lat_rsp_busy: got %b expected 0", fetch_busy); end
    n_checks++; if (inst_valid_if !== 1'b1) begin n_fail++; $display("FAIL lat_rsp_valid: got %b expected 1", inst_valid_if); end
    n_checks++; if (pc_if !== 32'h10) begin n_fail++; $display("FAIL lat_rsp_pc: got %h expected 00000010", pc_if); end
    step();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (imem.addr !== 32'h14) begin n_fail++; $display("FAIL lat_next_addr: got %h expected 00000014", imem.addr); end
    // Advance 0x14, 0x18, 0x1C with zero wait.
    mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
  endtask

  task automatic test_stall();
    mem_ready = 1'b1;
    stall_if  = 1'b1;
    #1;
    n_checks++; if (pc_if !== 32'h20) begin n_fail++; $display("FAIL st_rsp_pc: got %h expected 00000020", pc_if); end
    n_checks++; if (inst_valid_if !== 1'b1) begin n_fail++; $display("FAIL st_rsp_valid: got %b expected 1", inst_valid_if); end
    step();
    mem_ready   = 1'b0;
    mem_garbage = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req[%0d]: got %b expected 0", i, imem.req); end
      n_checks++; if (inst_if !== 32'hC0DE_0020) begin n_fail++; $display("FAIL st_hold_inst[%0d]: got %h expected c0de0020", i, inst_if); end
      n_checks++; if (pc_if !== 32'h20) begin n_fail++; $display("FAIL st_hold_pc[%0d]: got %h expected 00000020", i, pc_if); end
      n_checks++; if (inst_valid_if !== 1'b1) begin n_fail++; $display("FAIL st_hold_valid[%0d]: got %b expected 1", i, inst_valid_if); end
      n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL st_hold_busy[%0d]: got %b expected 0", i, fetch_busy); end
      step();
    end
    stall_if = 1'b0;
    #1;
    n_checks++; if (inst_if !== 32'hC0DE_0020) begin n_fail++; $display("FAIL st_release_inst: got %h expected c0de0020", inst_if); end
    step();
    mem_garbage = 1'b0;
    #1;
    n_checks++; if (imem.addr !== 32'h24) begin n_fail++; $display("FAIL st_next_addr: got %h expected 00000024", imem.addr); end
    n_checks++; if (imem.req !== 1'b1) begin n_fail++; $display("FAIL st_next_req: got %b expected 1", imem.req); end
    // Advance 0x24..0x3C (7 fetches) to land on 0x40.
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    mem_ready = 1'b0;
  endtask

  task automatic test_redirect_pending();
    #1;
    n_checks++; if (imem.addr !== 32'h40) begin n_fail++; $display("FAIL rd_pend_addr: got %h expected 00000040", imem.addr); end
    pc_src_id = 1'b1;
    target_id = 32'h103;
    #1;
    n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL rd_valid: got %b expected 0", inst_valid_if); end
    step();
    pc_src_id = 1'b0;
    #1;
    n_checks++; if (imem.req !== 1'b1) begin n_fail++; $display("FAIL rd_disc_req: got %b expected 1", imem.req); end
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rd_disc_busy: got %b expected 0", fetch_busy); end
    n_checks++; if (imem.addr !== 32'h100) begin n_fail++; $display("FAIL rd_disc_addr: got %h expected 00000100", imem.addr); end
    step();
    mem_ready = 1'b1;  // late response for 0x40
    #1;
    n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL rd_late_valid: got %b expected 0", inst_valid_if); end
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rd_late_busy: got %b expected 0", fetch_busy); end
    step();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (imem.addr !== 32'h100) begin n_fail++; $display("FAIL rd_next_addr: got %h expected 00000100", imem.addr); end
    n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rd_next_busy: got %b expected 1", fetch_busy); end
  endtask

  task automatic test_redirect_conflicts();
    pc_src_id = 1'b1;
    target_id = 32'h200;
    stall_if  = 1'b1;
    step();
    pc_src_id = 1'b0;
    stall_if  = 1'b0;
    #1;
    n_checks++; if (imem.addr !== 32'h100) begin n_fail++; $display("FAIL rs_addr: got %h expected 00000100", imem.addr); end
    n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rs_busy: got %b expected 1", fetch_busy); end
    mem_ready = 1'b1;
    pc_src_id = 1'b1;
    target_id = 32'h2FE;
    #1;
    n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL rr_valid: got %b expected 0", inst_valid_if); end
    n_checks++; if (inst_if !== NOP) begin n_fail++; $display("FAIL rr_inst: got %h expected %h", inst_if, NOP); end
    step();
    mem_ready = 1'b0;
    pc_src_id = 1'b0;
    #1;
    n_checks++; if (imem.addr !== 32'h2FC) begin n_fail++; $display("FAIL rr_addr: got %h expected 000002fc", imem.addr); end
    n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy: got %b expected 1", fetch_busy); end
  endtask

  task automatic test_bubble();
    mem_ready = 1'b1;
    bubble_if = 1'b1;
    #1;
    n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL bb_valid: got %b expected 0", inst_valid_if); end
    step();
    bubble_if = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_checks++; if (imem.addr !== 32'h2FC) begin n_fail++; $display("FAIL bb_addr: got %h expected 000002fc", imem.addr); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1;
    pc_src_id = 1'b1;
    target_id = 32'h80;
    step();
    mem_ready = 1'b0;
    pc_src_id = 1'b0;
    #1;
    n_checks++; if (imem.addr !== 32'h80) begin n_fail++; $display("FAIL rm_pre_addr: got %h expected 00000080", imem.addr); end
    rst       = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_checks++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b expected 0", imem.req); end
    n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", inst_valid_if); end
    n_checks++; if (inst_if !== NOP) begin n_fail++; $display("FAIL rm_inst: got %h expected %h", inst_if, NOP); end
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", fetch_busy); end
    n_checks++; if (imem.addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr: got %h expected 00000000", imem.addr); end
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (inst_valid_if !== 1'b0) begin n_fail++; $display("FAIL rm_late_valid: got %b expected 0", inst_valid_if); end
    step();
    #1;
    n_checks++; if (imem.req !== 1'b1) begin n_fail++; $display("FAIL rm_post_req: got %b expected 1", imem.req); end
    n_checks++; if (imem.addr !== 32'h0) begin n_fail++; $display("FAIL rm_post_addr: got %h expected 00000000", imem.addr); end
    n_checks++; if (pc_if !== 32'h0 || inst_valid_if !== 1'b1) begin n_fail++; $display("FAIL rm_post_inst: got pc %h valid %b expected pc 00000000 valid 1", pc_if, inst_valid_if); end
    mem_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    stall_if    = 1'b0;
    bubble_if   = 1'b0;
    pc_src_id   = 1'b0;
    target_id   = '0;
    mem_ready   = 1'b0;
    mem_garbage = 1'b0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_pending();
    test_redirect_conflicts();
    test_bubble();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
